// File: rtl/b10_b8_decoder.sv
// 8b/10b data-character decoder with independent running disparity per sub-block.
// The 6b (abcdei) and 4b (fghj) sub-blocks are looked up separately, each checked
// against its own running disparity, and the results are registered (1-cycle latency).
// Words flagged with a code or disparity error are counted in a saturating counter.
//
// Handshake: in_valid qualifies in_b10_d for one cycle. There is no back-pressure,
// so a word is taken on every edge where in_valid=1. out_valid rises after that
// edge for exactly one cycle per accepted word.
module b10_b8_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [10:1]      in_b10_d,
   input  logic             clr_cnt,
   output logic             out_valid,
   output logic [8:1]       out_b8_q,
   output logic             code_err,
   output logic             disp_err,
   output logic [2:1]       rd_q,
   output logic [CNT_W-1:0] err_cnt
);

   logic [5:0] sb6;
   logic [3:0] sb4;

   logic       ok6, ok4;
   logic [4:0] val6;
   logic [2:0] val4;
   logic       de6, de4;
   logic       rd6_n, rd4_n;

   logic             valid_q, valid_d;
   logic [8:1]       byte_q, byte_d;
   logic             code_err_q, code_err_d;
   logic             disp_err_q, disp_err_d;
   logic             rd6_q, rd6_d;
   logic             rd4_q, rd4_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign sb6 = in_b10_d[10:5];
   assign sb4 = in_b10_d[4:1];

   // 5b/6b lookup: both disparity forms of each data code map to the same 5-bit value.
   always_comb begin
      ok6  = 1'b1;
      val6 = 5'd0;
      case (sb6)
         6'b100111, 6'b011000: val6 = 5'd0;
         6'b011101, 6'b100010: val6 = 5'd1;
         6'b101101, 6'b010010: val6 = 5'd2;
         6'b110001:            val6 = 5'd3;
         6'b110101, 6'b001010: val6 = 5'd4;
         6'b101001:            val6 = 5'd5;
         6'b011001:            val6 = 5'd6;
         6'b111000, 6'b000111: val6 = 5'd7;
         6'b111001, 6'b000110: val6 = 5'd8;
         6'b100101:            val6 = 5'd9;
         6'b010101:            val6 = 5'd10;
         6'b110100:            val6 = 5'd11;
         6'b001101:            val6 = 5'd12;
         6'b101100:            val6 = 5'd13;
         6'b011100:            val6 = 5'd14;
         6'b010111, 6'b101000: val6 = 5'd15;
         6'b011011, 6'b100100: val6 = 5'd16;
         6'b100011:            val6 = 5'd17;
         6'b010011:            val6 = 5'd18;
         6'b110010:            val6 = 5'd19;
         6'b001011:            val6 = 5'd20;
         6'b101010:            val6 = 5'd21;
         6'b011010:            val6 = 5'd22;
         6'b111010, 6'b000101: val6 = 5'd23;
         6'b110011, 6'b001100: val6 = 5'd24;
         6'b100110:            val6 = 5'd25;
         6'b010110:            val6 = 5'd26;
         6'b110110, 6'b001001: val6 = 5'd27;
         6'b001110:            val6 = 5'd28;
         6'b101110, 6'b010001: val6 = 5'd29;
         6'b011110, 6'b100001: val6 = 5'd30;
         6'b101011, 6'b010100: val6 = 5'd31;
         default:              ok6  = 1'b0;
      endcase
   end

   // 3b/4b lookup: D.x.7 accepts both the primary and the alternate encodings.
   always_comb begin
      ok4  = 1'b1;
      val4 = 3'd0;
      case (sb4)
         4'b1011, 4'b0100:                   val4 = 3'd0;
         4'b1001:                            val4 = 3'd1;
         4'b0101:                            val4 = 3'd2;
         4'b1100, 4'b0011:                   val4 = 3'd3;
         4'b1101, 4'b0010:                   val4 = 3'd4;
         4'b1010:                            val4 = 3'd5;
         4'b0110:                            val4 = 3'd6;
         4'b1110, 4'b0001, 4'b0111, 4'b1000: val4 = 3'd7;
         default:                            ok4  = 1'b0;
      endcase
   end

   // 6b disparity check; the balanced restricted pair 111000/000111 must match the RD.
   always_comb begin
      rd6_n = rd6_q;
      de6   = 1'b0;
      if (ok6) begin
         if ($countones(sb6) == 4) begin
            de6   = rd6_q;
            rd6_n = 1'b1;
         end else if ($countones(sb6) == 2) begin
            de6   = !rd6_q;
            rd6_n = 1'b0;
         end else if (sb6 == 6'b111000) begin
            de6 = rd6_q;
         end else if (sb6 == 6'b000111) begin
            de6 = !rd6_q;
         end
      end
   end

   // 4b disparity check; the balanced restricted pair 1100/0011 must match the RD.
   always_comb begin
      rd4_n = rd4_q;
      de4   = 1'b0;
      if (ok4) begin
         if ($countones(sb4) == 3) begin
            de4   = rd4_q;
            rd4_n = 1'b1;
         end else if ($countones(sb4) == 1) begin
            de4   = !rd4_q;
            rd4_n = 1'b0;
         end else if (sb4 == 4'b1100) begin
            de4 = rd4_q;
         end else if (sb4 == 4'b0011) begin
            de4 = !rd4_q;
         end
      end
   end

   // Next-state: idle cycles clear the flags but hold data, RD and the counter.
   always_comb begin
      valid_d    = in_valid;
      byte_d     = byte_q;
      code_err_d = 1'b0;
      disp_err_d = 1'b0;
      rd6_d      = rd6_q;
      rd4_d      = rd4_q;
      cnt_d      = cnt_q;
      if (in_valid) begin
         byte_d     = {(ok4 ? val4 : 3'd0), (ok6 ? val6 : 5'd0)};
         code_err_d = !ok6 || !ok4;
         disp_err_d = de6 || de4;
         rd6_d      = rd6_n;
         rd4_d      = rd4_n;
         if ((code_err_d || disp_err_d) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
      if (clr_cnt) begin
         cnt_d = '0;
      end
   end

   // Output and state registers; reset wins over everything, including a word in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         byte_q     <= '0;
         code_err_q <= 1'b0;
         disp_err_q <= 1'b0;
         rd6_q      <= 1'b0;
         rd4_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         byte_q     <= byte_d;
         code_err_q <= code_err_d;
         disp_err_q <= disp_err_d;
         rd6_q      <= rd6_d;
         rd4_q      <= rd4_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_b8_q  = byte_q;
   assign code_err  = code_err_q;
   assign disp_err  = disp_err_q;
   assign rd_q      = {rd6_q, rd4_q};
   assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_b10_b8_decoder.sv
// Directed bench for b10_b8_decoder. A second instance with a 2-bit counter shares
// the stimulus so counter saturation can be observed quickly.
module tb_b10_b8_decoder;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst      = 1'b1;
   logic        in_valid = 1'b0;
   logic [10:1] in_b10_d = '0;
   logic        clr_cnt  = 1'b0;

   logic       out_valid, code_err, disp_err;
   logic [8:1] out_b8_q;
   logic [2:1] rd_q;
   logic [7:0] err_cnt;

   logic       out_valid2, code_err2, disp_err2;
   logic [8:1] out_b8_q2;
   logic [2:1] rd_q2;
   logic [1:0] err_cnt2;

   b10_b8_decoder #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_b10_d(in_b10_d), .clr_cnt(clr_cnt),
      .out_valid(out_valid), .out_b8_q(out_b8_q), .code_err(code_err),
      .disp_err(disp_err), .rd_q(rd_q), .err_cnt(err_cnt)
   );

   b10_b8_decoder #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_b10_d(in_b10_d), .clr_cnt(clr_cnt),
      .out_valid(out_valid2), .out_b8_q(out_b8_q2), .code_err(code_err2),
      .disp_err(disp_err2), .rd_q(rd_q2), .err_cnt(err_cnt2)
   );

   // ---------------- counters / scoreboard ----------------
   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference encoder (independent RD per sub-block) ----------------
   logic [5:0] t6 [0:31] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
   };
   logic [3:0] t4 [0:7] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
   };
   logic rd6_m = 1'b0;
   logic rd4_m = 1'b0;

   task automatic encode(input logic [7:0] b, output logic [9:0] w);
      logic [5:0] c6;
      logic [3:0] c4;
      c6 = t6[b[4:0]];
      if (b[4:0] == 5'd7) begin
         c6 = rd6_m ? 6'b000111 : 6'b111000;
      end else if ($countones(c6) != 3) begin
         if (rd6_m) c6 = ~c6;
         rd6_m = ~rd6_m;
      end
      c4 = t4[b[7:5]];
      if (b[7:5] == 3'd3) begin
         c4 = rd4_m ? 4'b0011 : 4'b1100;
      end else if ($countones(c4) != 2) begin
         if (rd4_m) c4 = ~c4;
         rd4_m = ~rd4_m;
      end
      w = {c6, c4};
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic v, input logic [9:0] w, input logic c);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in_b10_d = w;
      clr_cnt  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [9:0] w);
      drive(1'b0, 1'b1, w, 1'b0);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 10'd0, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b1, 10'b1001111011, 1'b0);
      drive(1'b1, 1'b0, 10'd0, 1'b0);
      rd6_m = 1'b0;
      rd4_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] w;
      encode(b, w);
      exp_q.push_back(b);
      send(w);
      chk("stream_valid", out_valid, 1);
      chk("stream_byte", out_b8_q, exp_q.pop_front());
      chk("stream_errs", {code_err, disp_err}, 2'b00);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      string s;
      s = "Hello, World!";

      // reset with a word presented: nothing comes out
      do_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_byte", out_b8_q, 8'h00);
      chk("rst_errs", {code_err, disp_err}, 2'b00);
      chk("rst_rd", rd_q, 2'b00);
      chk("rst_cnt", err_cnt, 0);

      // D.0.0 in both disparity forms
      send(10'b100111_1011);
      chk("d00a_valid", out_valid, 1);
      chk("d00a_byte", out_b8_q, 8'h00);
      chk("d00a_rd", rd_q, 2'b11);
      chk("d00a_errs", {code_err, disp_err}, 2'b00);
      send(10'b011000_0100);
      chk("d00b_byte", out_b8_q, 8'h00);
      chk("d00b_rd", rd_q, 2'b00);
      chk("d00b_errs", {code_err, disp_err}, 2'b00);
      chk("d00b_cnt", err_cnt, 0);

      // 'H' then an idle cycle: data and RD hold, valid drops
      do_reset();
      send(10'b111001_0101);
      chk("h_byte", out_b8_q, 8'h48);
      chk("h_rd", rd_q, 2'b10);
      idle();
      chk("idle_valid", out_valid, 0);
      chk("idle_byte", out_b8_q, 8'h48);
      chk("idle_rd", rd_q, 2'b10);

      // full text stream with occasional gaps
      do_reset();
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
         if ($urandom_range(0, 3) == 0) begin
            idle();
            chk("gap_valid", out_valid, 0);
         end
      end
      chk("stream_cnt", err_cnt, 0);

      // wrong-direction disparity at reset RD
      do_reset();
      send(10'b011000_0100);
      chk("rdneg_byte", out_b8_q, 8'h00);
      chk("rdneg_errs", {code_err, disp_err}, 2'b01);
      chk("rdneg_rd", rd_q, 2'b00);
      chk("rdneg_cnt", err_cnt, 1);

      // invalid 6b sub-block only, then invalid 4b only
      do_reset();
      send(10'b111111_0000);
      chk("bad6_errs", {code_err, disp_err}, 2'b10);
      chk("bad6_lo", out_b8_q[5:1], 5'd0);
      chk("bad6_rd", rd_q, 2'b00);
      chk("bad6_cnt", err_cnt, 1);
      do_reset();
      send(10'b100111_1011);
      send(10'b111111_0101);
      chk("bad6b_byte", out_b8_q, 8'h40);
      chk("bad6b_errs", {code_err, disp_err}, 2'b10);
      chk("bad6b_rd", rd_q, 2'b11);
      chk("bad6b_cnt", err_cnt, 1);
      send(10'b100110_1111);
      chk("bad4_byte", out_b8_q, 8'h19);
      chk("bad4_errs", {code_err, disp_err}, 2'b10);
      chk("bad4_cnt", err_cnt, 2);

      // restricted forms: wrong for RD=+1, then right
      send(10'b111000_1100);
      chk("rstr_bad_byte", out_b8_q, 8'h67);
      chk("rstr_bad_errs", {code_err, disp_err}, 2'b01);
      chk("rstr_bad_rd", rd_q, 2'b11);
      chk("rstr_bad_cnt", err_cnt, 3);
      send(10'b000111_0011);
      chk("rstr_ok_byte", out_b8_q, 8'h67);
      chk("rstr_ok_errs", {code_err, disp_err}, 2'b00);
      chk("rstr_ok_cnt", err_cnt, 3);

      // code and disparity error in the same word, then idle clears flags
      send(10'b111111_1011);
      chk("both_errs", {code_err, disp_err}, 2'b11);
      chk("both_byte", out_b8_q, 8'h00);
      chk("both_cnt", err_cnt, 4);
      idle();
      chk("idle2_flags", {out_valid, code_err, disp_err}, 3'b000);
      chk("idle2_rd", rd_q, 2'b11);
      chk("idle2_cnt", err_cnt, 4);

      // alternate D.x.7 in both forms
      send(10'b011000_1000);
      chk("a7n_byte", out_b8_q, 8'hE0);
      chk("a7n_rd", rd_q, 2'b00);
      chk("a7n_errs", {code_err, disp_err}, 2'b00);
      send(10'b100111_0111);
      chk("a7p_byte", out_b8_q, 8'hE0);
      chk("a7p_rd", rd_q, 2'b11);

      // clear on an idle cycle
      drive(1'b0, 1'b0, 10'd0, 1'b1);
      chk("clr_idle_cnt", err_cnt, 0);

      // saturation of the narrow counter, then clear beats increment
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         send(10'b111111_0000);
         chk("sat_cnt8", err_cnt, k);
         chk("sat_cnt2", err_cnt2, (k > 3) ? 3 : k);
      end
      chk("sat2_flags", {out_valid2, code_err2, disp_err2}, 3'b110);
      chk("sat2_rd_byte", {rd_q2, out_b8_q2}, 10'd0);
      drive(1'b0, 1'b1, 10'b111111_0000, 1'b1);
      chk("sat_clr_cnt2", err_cnt2, 0);
      chk("sat_clr_cnt8", err_cnt, 0);
      chk("sat_clr_err", code_err, 1);

      // reset mid-stream with a word present
      do_reset();
      send(10'b011000_0100);
      send_byte(8'h41);
      send_byte(8'h07);
      drive(1'b1, 1'b1, 10'b100111_1011, 1'b0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_rd", rd_q, 2'b00);
      chk("mid_rst_cnt", err_cnt, 0);
      rd6_m = 1'b0;
      rd4_m = 1'b0;
      send_byte(8'h00);
      chk("mid_rd_after", rd_q, 2'b11);
      send_byte(8'hFF);
      send_byte(8'h63);

      if (fail_cnt != 0) $display("%0d comparisons did not match", fail_cnt);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
